// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   Minutes/seconds stopwatch and countdown timer. It advances one step per
//   cycle in which tick_i is high. It supports run/pause, a preset (adjust)
//   mode, up/down counting, a rollover pulse and an expiry flag.
//
// Parameters
//   W        width of each count field
//   SEC_MAX  last seconds value (seconds wrap at SEC_MAX+1)
//   MIN_MAX  last minutes value (minutes wrap at MIN_MAX+1)
//
// Ports
//   timer_i     clock, rising edge
//   reset_i     synchronous active-low reset
//   tick_i      count strobe, one step per cycle high
//   pause_i     pulse: toggles run/pause, clears expiry
//   adj_i       level: request adjust mode
//   sel_i       adjust target: 0 = seconds, 1 = minutes
//   adj_step_i  pulse: +1 on the selected field while adjusting
//   down_i      direction: 0 = up, 1 = down (sampled on each tick)
//   minutes_o   current minutes
//   seconds_o   current seconds
//   running_o   high in RUN
//   adjusting_o high in ADJUST
//   wrap_o      one-cycle pulse after a full up-count rollover
//   done_o      high in EXPIRED
module stopwatch_counter #(
    parameter int W       = 6,
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59
) (
    input  logic         timer_i,
    input  logic         reset_i,
    input  logic         tick_i,
    input  logic         pause_i,
    input  logic         adj_i,
    input  logic         sel_i,
    input  logic         adj_step_i,
    input  logic         down_i,
    output logic [W-1:0] minutes_o,
    output logic [W-1:0] seconds_o,
    output logic         running_o,
    output logic         adjusting_o,
    output logic         wrap_o,
    output logic         done_o
);

    localparam logic [W-1:0] SEC_LIM = W'(SEC_MAX);
    localparam logic [W-1:0] MIN_LIM = W'(MIN_MAX);
    localparam logic [W-1:0] ONE     = W'(1);

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        RUN     = 2'd1,
        ADJUST  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sec_q, sec_d;
    logic [W-1:0]   min_q, min_d;
    logic           wrap_q, wrap_d;

    always_ff @(posedge timer_i) begin
        if (!reset_i) begin
            state_q <= PAUSED;
            sec_q   <= '0;
            min_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        wrap_d  = 1'b0;

        if (adj_i) begin
            // adj outranks pause and tick. A step pulse counts only once the
            // block is already in ADJUST, not on the entry cycle.
            state_d = ADJUST;
            if (state_q == ADJUST && adj_step_i) begin
                if (sel_i) begin
                    min_d = (min_q == MIN_LIM) ? '0 : min_q + ONE;
                end else begin
                    sec_d = (sec_q == SEC_LIM) ? '0 : sec_q + ONE;
                end
            end
        end else begin
            case (state_q)
                ADJUST: begin
                    state_d = PAUSED;
                end
                PAUSED: begin
                    if (pause_i) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick_i) begin
                        if (!down_i) begin
                            if (sec_q != SEC_LIM) begin
                                sec_d = sec_q + ONE;
                            end else begin
                                sec_d = '0;
                                if (min_q == MIN_LIM) begin
                                    min_d  = '0;
                                    wrap_d = 1'b1;
                                end else begin
                                    min_d = min_q + ONE;
                                end
                            end
                        end else begin
                            if (sec_q != '0) begin
                                sec_d = sec_q - ONE;
                            end else if (min_q != '0) begin
                                sec_d = SEC_LIM;
                                min_d = min_q - ONE;
                            end
                            // Also covers a down tick taken while already at 00:00.
                            if (sec_d == '0 && min_d == '0) begin
                                state_d = EXPIRED;
                            end
                        end
                    end
                    // The tick above is still applied; the pause then wins the state.
                    if (pause_i) begin
                        state_d = PAUSED;
                    end
                end
                EXPIRED: begin
                    if (pause_i) begin
                        state_d = PAUSED;
                    end
                end
                default: begin
                    state_d = PAUSED;
                end
            endcase
        end
    end

    assign minutes_o   = min_q;
    assign seconds_o   = sec_q;
    assign running_o   = (state_q == RUN);
    assign adjusting_o = (state_q == ADJUST);
    assign done_o      = (state_q == EXPIRED);
    assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Testbench for stopwatch_counter: directed vectors feed a scoreboard queue.
// A negedge monitor compares each queued expectation in the cycle it targets.
module tb_stopwatch_counter;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tick, pause, adj, sel, adj_step, down;
    logic [W-1:0] minutes, seconds;
    logic         running, adjusting, wrap, done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int           cyc;
        logic [W-1:0] mn;
        logic [W-1:0] sc;
        logic         r;
        logic         a;
        logic         w;
        logic         d;
        string        nm;
    } exp_t;

    exp_t sb_q[$];

    stopwatch_counter #(.W(W), .SEC_MAX(59), .MIN_MAX(59)) dut (
        .timer_i     (clk),
        .reset_i     (rst_n),
        .tick_i      (tick),
        .pause_i     (pause),
        .adj_i       (adj),
        .sel_i       (sel),
        .adj_step_i  (adj_step),
        .down_i      (down),
        .minutes_o   (minutes),
        .seconds_o   (seconds),
        .running_o   (running),
        .adjusting_o (adjusting),
        .wrap_o      (wrap),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (minutes !== e.mn || seconds !== e.sc || running !== e.r ||
                adjusting !== e.a || wrap !== e.w || done !== e.d) begin
                errors++;
                $display("FAIL %s: got %0d:%0d run=%b adj=%b wrap=%b done=%b, want %0d:%0d run=%b adj=%b wrap=%b done=%b",
                         e.nm, minutes, seconds, running, adjusting, wrap, done,
                         e.mn, e.sc, e.r, e.a, e.w, e.d);
            end else begin
                $display("ok   %s: %0d:%0d run=%b adj=%b wrap=%b done=%b",
                         e.nm, minutes, seconds, running, adjusting, wrap, done);
            end
        end
    end

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic step(input logic rs, input logic tk, input logic ps,
                        input logic aj, input logic sl, input logic st,
                        input logic dn, input int em, input int es,
                        input logic er, input logic ea, input logic ew,
                        input logic ed, input string nm);
        exp_t e;
        rst_n    = rs;
        tick     = tk;
        pause    = ps;
        adj      = aj;
        sel      = sl;
        adj_step = st;
        down     = dn;
        e.cyc = cyc + 1;
        e.mn  = W'(em);
        e.sc  = W'(es);
        e.r   = er;
        e.a   = ea;
        e.w   = ew;
        e.d   = ed;
        e.nm  = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; pause = 1'b0; adj = 1'b0;
        sel = 1'b0; adj_step = 1'b0; down = 1'b0;
        @(posedge clk);
        #1;

        //     rs tk ps aj sl st dn  mm ss  r  a  w  d
        step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, "idle_paused");
        step(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, "tick_ignored_paused");
        step(1, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, "pause_to_run");
        for (int i = 0; i < 60; i++)
            step(1, 1, 0, 0, 0, 0, 0, (i == 59) ? 1 : 0, (i + 1) % 60,
                 1, 0, 0, 0, "up_tick");

        // Preset 59:58 and roll over.
        step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, "reset2");
        step(1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, "enter_adjust");
        for (int i = 0; i < 59; i++)
            step(1, 0, 0, 1, 1, 1, 0, i + 1, 0, 0, 1, 0, 0, "adj_min");
        for (int i = 0; i < 58; i++)
            step(1, 0, 0, 1, 0, 1, 0, 59, i + 1, 0, 1, 0, 0, "adj_sec");
        step(1, 0, 0, 0, 0, 0, 0, 59, 58, 0, 0, 0, 0, "leave_adjust");
        step(1, 0, 1, 0, 0, 0, 0, 59, 58, 1, 0, 0, 0, "run_5958");
        step(1, 1, 0, 0, 0, 0, 0, 59, 59, 1, 0, 0, 0, "tick_5959");
        step(1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, "rollover_wrap");
        step(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, "wrap_drops");

        // Countdown from 00:02 to expiry.
        step(1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, "adjust_from_run");
        step(1, 0, 0, 1, 0, 1, 0,  0, 1, 0, 1, 0, 0, "adj_sec1");
        step(1, 0, 0, 1, 0, 1, 0,  0, 2, 0, 1, 0, 0, "adj_sec2");
        step(1, 0, 0, 0, 0, 0, 1,  0, 2, 0, 0, 0, 0, "leave_adjust2");
        step(1, 0, 1, 0, 0, 0, 1,  0, 2, 1, 0, 0, 0, "run_down");
        step(1, 1, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0, "down_0001");
        step(1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, "down_expire");
        step(1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, "expired_hold1");
        step(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, "expired_hold2");
        step(1, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, "expired_pause");
        step(1, 0, 1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0, "run_at_zero");
        step(1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, "down_at_zero");
        step(1, 0, 0, 1, 0, 0, 1,  0, 0, 0, 1, 0, 0, "adjust_from_expired");

        // Borrow from minutes: 01:00 down -> 00:59.
        step(1, 0, 0, 1, 1, 1, 1,  1, 0, 0, 1, 0, 0, "adj_min1");
        step(1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, "leave_adjust3");
        step(1, 0, 1, 0, 0, 0, 1,  1, 0, 1, 0, 0, 0, "run_0100");
        step(1, 1, 0, 0, 0, 0, 1,  0, 59, 1, 0, 0, 0, "down_borrow");
        step(1, 0, 1, 0, 0, 0, 0,  0, 59, 0, 0, 0, 0, "pause_0059");

        // Seconds wrap in adjust without carry; ticks/pause ignored in adjust.
        step(1, 0, 0, 1, 0, 0, 0,  0, 59, 0, 1, 0, 0, "enter_adjust4");
        step(1, 0, 0, 1, 0, 1, 0,  0, 0, 0, 1, 0, 0, "adj_sec_wrap");
        step(1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, "tick_in_adjust");
        step(1, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, "pause_in_adjust");
        for (int i = 0; i < 10; i++)
            step(1, 0, 0, 1, 0, 1, 0, 0, i + 1, 0, 1, 0, 0, "adj_sec_to10");
        step(1, 0, 0, 0, 0, 0, 0,  0, 10, 0, 0, 0, 0, "leave_adjust4");
        step(1, 0, 1, 0, 0, 0, 0,  0, 10, 1, 0, 0, 0, "run_0010");
        step(1, 1, 1, 0, 0, 0, 0,  0, 11, 0, 0, 0, 0, "pause_tick_run");
        step(1, 1, 0, 0, 0, 0, 0,  0, 11, 0, 0, 0, 0, "paused_hold1");
        step(1, 1, 0, 0, 0, 0, 0,  0, 11, 0, 0, 0, 0, "paused_hold2");
        step(1, 1, 1, 0, 0, 0, 0,  0, 11, 1, 0, 0, 0, "pause_tick_paused");
        step(1, 0, 0, 0, 0, 0, 1,  0, 11, 1, 0, 0, 0, "down_level_only");

        // Reach 12:34 in RUN, then reset with tick and pause.
        step(1, 0, 0, 1, 0, 0, 0,  0, 11, 0, 1, 0, 0, "enter_adjust5");
        for (int i = 0; i < 12; i++)
            step(1, 0, 0, 1, 1, 1, 0, i + 1, 11, 0, 1, 0, 0, "adj_min_to12");
        for (int i = 0; i < 23; i++)
            step(1, 0, 0, 1, 0, 1, 0, 12, 12 + i, 0, 1, 0, 0, "adj_sec_to34");
        step(1, 0, 0, 0, 0, 0, 0, 12, 34, 0, 0, 0, 0, "leave_adjust5");
        step(1, 0, 1, 0, 0, 0, 0, 12, 34, 1, 0, 0, 0, "run_1234");
        step(0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, "reset_mid_run");
        step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, "after_reset");

        // Let the monitor drain; anything left over is a missed comparison.
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
